// File: rtl/ws_input_skew_feeder_pkg.sv
// Shared types and constants for the west-edge skew feeder of a weight-stationary tile.
package ws_input_skew_feeder_pkg;

    typedef enum logic [1:0] {
        SKEW_IDLE,
        SKEW_STREAM,
        SKEW_DRAIN
    } skew_state_e;

    localparam int SKEW_CNT_W = 16;

endpackage

// File: rtl/ws_input_skew_feeder_if.sv
// Vector handshake from the activation buffer and per-lane skewed bus into the PE array.
interface ws_input_skew_feeder_if #(
    parameter int ROWS   = 32,
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [ROWS*DATA_W-1:0]   in_data;
    logic [ROWS-1:0]          out_valid;
    logic [ROWS*DATA_W-1:0]   out_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/ws_input_skew_feeder_skew_delay_line.sv
// Enabled shift register carrying one lane's data and valid; output is the last stage.
module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
        end else if (en_i) begin
            data_q[0]  <= data_i;
            valid_q[0] <= valid_i;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];
endmodule

// File: rtl/ws_input_skew_feeder.sv
// Accepts activation vectors and feeds them diagonally skewed (lane i delayed i cycles)
// into the west edge of a WS systolic tile, draining and pulsing done after the last one.
module ws_input_skew_feeder
    import ws_input_skew_feeder_pkg::*;
#(
    parameter int ROWS   = 32,
    parameter int DATA_W = 16,
    parameter int CNT_W  = SKEW_CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     k_len_i,
    input  logic                 array_en_i,
    ws_input_skew_feeder_if.slave feed,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int DRAIN_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    skew_state_e        state_q, state_d;
    logic [CNT_W-1:0]   k_len_q, k_len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               zero_q, zero_d;
    logic               accept;
    logic               in_ready;
    logic               done;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SKEW_IDLE;
            k_len_q <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            zero_q  <= zero_d;
        end
    end

    // Everything advances only on enabled cycles; a disabled cycle is invisible to the schedule.
    always_comb begin
        state_d  = state_q;
        k_len_d  = k_len_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        zero_d   = zero_q;
        accept   = 1'b0;
        in_ready = 1'b0;
        done     = 1'b0;
        if (array_en_i) begin
            zero_d = 1'b0;
            done   = zero_q;
            case (state_q)
                SKEW_IDLE: begin
                    if (start_i && !zero_q) begin
                        if (k_len_i != '0) begin
                            k_len_d = k_len_i;
                            cnt_d   = '0;
                            state_d = SKEW_STREAM;
                        end else begin
                            zero_d = 1'b1;
                        end
                    end
                end
                SKEW_STREAM: begin
                    in_ready = 1'b1;
                    if (feed.in_valid) begin
                        accept = 1'b1;
                        cnt_d  = cnt_inc;
                        if (cnt_inc == k_len_q) begin
                            state_d = SKEW_DRAIN;
                            drain_d = DRAIN_W'(ROWS - 1);
                        end
                    end
                end
                SKEW_DRAIN: begin
                    if (drain_q == '0) begin
                        done    = 1'b1;
                        state_d = SKEW_IDLE;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
                default: state_d = SKEW_IDLE;
            endcase
        end
    end

    assign feed.in_ready = in_ready;
    assign busy_o        = (state_q != SKEW_IDLE);
    assign done_o        = done;

    logic [ROWS*DATA_W-1:0] out_data;
    logic [ROWS-1:0]        out_valid;

    // Non-accepted cycles push zero data with valid low, so bubbles are always clean.
    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        logic [DATA_W-1:0] lane_din;
        assign lane_din = accept ? feed.in_data[i*DATA_W +: DATA_W] : '0;

        skew_delay_line #(
            .DEPTH  (i + 1),
            .DATA_W (DATA_W)
        ) u_dly (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .en_i    (array_en_i),
            .data_i  (lane_din),
            .valid_i (accept),
            .data_o  (out_data[i*DATA_W +: DATA_W]),
            .valid_o (out_valid[i])
        );
    end

    assign feed.out_data  = out_data;
    assign feed.out_valid = out_valid;
endmodule
